datareg_arbiter: RTL and testbench
==================================

# datareg_arbiter

Round-robin write arbiter and sequencer for the shared 14-bit data register. Up to N_REQ requesters each present a write request and data word. The block grants one requester at a time, captures its word into the register it owns, and acknowledges completion. It sits between the input/control units and the data register consumers, and is the only writer of the shared value.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 14, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester write request, level, held until ack or abandoned
- wdata  in  N_REQ*DW  per-requester write data; slice i = wdata[i*DW +: DW]
- clr  in  1  synchronous clear of stored value, aborts any in-flight grant
- gnt  out  N_REQ  one-hot grant, high for exactly the GRANT cycle
- ack  out  N_REQ  one-hot write-complete, high for exactly the COMMIT cycle
- busy  out  1  high in GRANT and COMMIT
- data_out  out  DW  stored register value
- owner  out  $clog2(N_REQ)  index of requester that last wrote data_out
- upd  out  1  one-cycle pulse, high in the cycle data_out first shows a new committed word

## Operation
- FSM states: IDLE, GRANT, COMMIT. Reset state is IDLE.
- IDLE: if any req bit is set, pick winner sel, latch it, and go to GRANT. Otherwise stay in IDLE.
- Winner search starts at last+1 and wraps modulo N_REQ; the first set req bit wins.
- GRANT: gnt[sel]=1. On the closing edge:
  - If req[sel] is still 1: data register <= wdata[sel], owner <= sel, go to COMMIT.
  - If req[sel] has dropped: abandoned. No load, no ack, last unchanged, go to IDLE.
- COMMIT: ack[sel]=1, upd=1, last <= sel on the closing edge, then go to IDLE.
- Requester drops req in the cycle after ack. A req still high in the following IDLE is treated as a new request and is arbitrated normally.
- clr=1 in any state:
  - data_out <= 0 next edge and the FSM goes to IDLE.
  - A pending GRANT is aborted: no load, no ack, last unchanged.
  - In COMMIT, the ack/upd already asserted that cycle stand, but data_out is still cleared.
  - upd is not asserted for clr.
- Requests other than sel that arrive during GRANT/COMMIT wait. No request is lost while it stays asserted.
- req changes outside IDLE do not affect sel.
- Reset values:
  - data_out=0, owner=0, last=N_REQ-1, so requester 0 wins first.
  - gnt=0, ack=0, busy=0, upd=0.

## Timing
- Outputs gnt, ack, busy, upd decode from state/sel flops only. There is no combinational input-to-output path.
- Request first sampled high in IDLE at edge E:
  - gnt high in cycle E+1.
  - data_out, owner, ack, upd updated/high in cycle E+2.
  - IDLE again at E+3.
- Throughput: one write per 3 cycles. With requests held continuously, service strictly rotates among active requesters.
- wdata[sel] must be stable at the edge closing GRANT. It is sampled only at that edge.
- Asynchronous reset mid-operation returns to reset values immediately, with no ack for the in-flight request.

## Configuration
- DATAREG_ARB_FIXED_PRI_EN defined:
  - Fixed priority; the lowest set req index always wins.
  - The last pointer is not implemented.
  - Starvation of higher indices is permitted.
- Not defined: round-robin as described in Operation.

## Structure
- Shared package datareg_pkg holds:
  - DATAREG_DW=14
  - the FSM state enum (IDLE, GRANT, COMMIT)
  - the index-width helper for N_REQ
- Sub-module datareg_rr_pick: combinational picker with inputs req and last, outputs winner index and valid.
  - Under DATAREG_ARB_FIXED_PRI_EN it reduces to a lowest-index priority encoder.
- The storage is a DW-bit flop bank with load enable and synchronous clear, inside datareg_arbiter.

## Test plan
- Reset, then req=4'b0001, wdata[0]=14'h1ABC:
  - gnt=0001 one cycle later; next cycle ack=0001, upd=1, data_out=14'h1ABC, owner=0.
- req=4'b1111 held continuously:
  - round-robin build: grant order 0,1,2,3,0.
  - DATAREG_ARB_FIXED_PRI_EN build: grant order 0,0,0.
- Requester 2 drops req during its GRANT cycle:
  - no ack, data_out unchanged, upd=0.
  - next winner search still starts at last+1.
- clr pulsed during GRANT with data_out=14'h0055:
  - next cycle data_out=0, no ack, FSM in IDLE.
  - the request is re-granted afterwards if still held.
- rst_n low mid-COMMIT:
  - all outputs go to 0 immediately, owner=0.
  - after release with req=4'b1000, requester 3 is granted and data_out loads wdata[3].

Source files
------------

// File: rtl/datareg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datareg_pkg
// Description : Shared types and helpers for the data register arbiter:
//               data width, FSM state encoding and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package datareg_pkg;

    localparam int DATAREG_DW = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2
    } dr_state_t;

    // Width of an index able to address n requesters (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/datareg_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : datareg_rr_pick
// Description : Combinational winner picker. Round-robin search starting at
//               last+1 and wrapping; with DATAREG_ARB_FIXED_PRI_EN defined it
//               becomes a lowest-index priority encoder and ignores last.
// Revision    : 1.0 - initial release
// ============================================================================
module datareg_rr_pick
    import datareg_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    winner,
    output logic             valid
);

`ifdef DATAREG_ARB_FIXED_PRI_EN

    // Lowest set index wins; scanning downward lets the lowest overwrite
    always_comb begin
        winner = '0;
        valid  = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                winner = IW'(k);
            end
        end
    end

`else

    logic [N_REQ-1:0] w_rot;
    int               w_pos;

    // Rotate so bit k holds requester (last+1+k) mod N_REQ, then take lowest k
    always_comb begin
        w_rot  = N_REQ'({req, req} >> (int'(last) + 1));
        w_pos  = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_pos = int'(last) + 1 + k;
                if (w_pos >= N_REQ) begin
                    w_pos = w_pos - N_REQ;
                end
                winner = IW'(w_pos);
                valid  = 1'b1;
            end
        end
    end

`endif

endmodule
`default_nettype wire

// File: rtl/datareg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : datareg_arbiter
// Description : Round-robin write arbiter and sequencer for the shared data
//               register. IDLE -> GRANT -> COMMIT, one write per 3 cycles.
//               Define DATAREG_ARB_FIXED_PRI_EN for fixed lowest-index
//               priority (no last pointer).
// Revision    : 1.0 - initial release
// ============================================================================
module datareg_arbiter
    import datareg_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int DW    = DATAREG_DW,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] wdata,
    input  logic                clr,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                busy,
    output logic [DW-1:0]       data_out,
    output logic [IW-1:0]       owner,
    output logic                upd
);

    dr_state_t      r_state;
    logic [IW-1:0]  r_sel;
    logic [IW-1:0]  w_last;
    logic [IW-1:0]  w_winner;
    logic           w_valid;
    logic [DW-1:0]  w_words [N_REQ];

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_words[i] = wdata[i*DW +: DW];
    end

`ifdef DATAREG_ARB_FIXED_PRI_EN
    assign w_last = IW'(N_REQ - 1);
`else
    logic [IW-1:0] r_last;

    // Remember the most recent committed requester; a commit stands even if clr arrives with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IW'(N_REQ - 1);
        end else if (r_state == COMMIT) begin
            r_last <= r_sel;
        end
    end

    assign w_last = r_last;
`endif

    datareg_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .last   (w_last),
        .winner (w_winner),
        .valid  (w_valid)
    );

    // Sequencer with registered strobes so no input reaches an output combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            gnt     <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            upd     <= 1'b0;
        end else begin
            gnt <= '0;
            ack <= '0;
            upd <= 1'b0;
            if (clr) begin
                r_state <= IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_valid) begin
                            r_sel   <= w_winner;
                            gnt     <= onehot(w_winner);
                            busy    <= 1'b1;
                            r_state <= GRANT;
                        end
                    end
                    GRANT: begin
                        if (req[r_sel]) begin
                            ack     <= onehot(r_sel);
                            upd     <= 1'b1;
                            r_state <= COMMIT;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    COMMIT: begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Shared register bank: clear wins over load; load only if the grantee still requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            owner    <= '0;
        end else if (clr) begin
            data_out <= '0;
        end else if (r_state == GRANT && req[r_sel]) begin
            data_out <= w_words[r_sel];
            owner    <= r_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datareg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_datareg_arbiter
// Description : Self-checking bench for datareg_arbiter (N_REQ=4, DW=14).
//               Expected grants/commits are queued as stimulus is driven and
//               compared by a monitor when the DUT strobes gnt/ack/upd.
//               Honors DATAREG_ARB_FIXED_PRI_EN for the expected grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datareg_arbiter;

    localparam int N  = 4;
    localparam int DW = 14;

    typedef struct packed {
        logic [N-1:0]  ack;
        logic [DW-1:0] data;
        logic [1:0]    owner;
    } commit_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] wdata;
    logic            clr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            busy;
    logic [DW-1:0]   data_out;
    logic [1:0]      owner;
    logic            upd;

    int n_assert = 0;
    int n_fail   = 0;

    logic [N-1:0] gq [$];
    commit_t      cq [$];
    logic [N-1:0] mon_g;
    commit_t      mon_c;

    logic [DW-1:0] words [N] = '{14'h0AA0, 14'h1001, 14'h2002, 14'h3003};

    datareg_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
        .clr      (clr),
        .gnt      (gnt),
        .ack      (ack),
        .busy     (busy),
        .data_out (data_out),
        .owner    (owner),
        .upd      (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_g(input int idx);
        gq.push_back(N'(1) << idx);
    endtask

    task automatic push_c(input int idx, input logic [DW-1:0] d);
        commit_t c;
        c.ack   = N'(1) << idx;
        c.data  = d;
        c.owner = 2'(idx);
        cq.push_back(c);
    endtask

    task automatic set_word(input int idx, input logic [DW-1:0] d);
        wdata[idx*DW +: DW] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gnt"},  gnt,  0);
        chk({tag, "_ack"},  ack,  0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_upd"},  upd,  0);
    endtask

    // Scoreboard: every grant or commit strobe must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt !== '0) begin
                mon_g = '0;
                if (gq.size() > 0) mon_g = gq.pop_front();
                chk("gnt_order", gnt, mon_g);
            end
            if (ack !== '0 || upd !== 1'b0) begin
                mon_c = '0;
                if (cq.size() > 0) mon_c = cq.pop_front();
                chk("commit_ack",   ack,      mon_c.ack);
                chk("commit_upd",   upd,      1);
                chk("commit_data",  data_out, mon_c.data);
                chk("commit_owner", owner,    mon_c.owner);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wdata = '0;
        clr   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_data",  data_out, 0);
        chk("reset_owner", owner,    0);
        rst_n = 1'b1;

        // Single write from requester 0: gnt next cycle, commit the cycle after
        @(negedge clk);
        set_word(0, 14'h1ABC);
        req = 4'b0001;
        push_g(0);
        push_c(0, 14'h1ABC);
        @(posedge clk); #1;
        chk("t1_gnt",  gnt,  4'b0001);
        chk("t1_busy", busy, 1);
        chk("t1_ack0", ack,  0);
        @(posedge clk); #1;
        chk("t1_ack",   ack,      4'b0001);
        chk("t1_upd",   upd,      1);
        chk("t1_data",  data_out, 14'h1ABC);
        chk("t1_owner", owner,    0);
        chk("t1_busyc", busy,     1);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        check_idle_outputs("t1_after");

        // Fresh reset, then all four requesting continuously
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_word(i, words[i]);
        req = 4'b1111;
`ifdef DATAREG_ARB_FIXED_PRI_EN
        for (int i = 0; i < 5; i++) begin
            push_g(0);
            push_c(0, words[0]);
        end
`else
        for (int i = 0; i < 5; i++) begin
            push_g(i % N);
            push_c(i % N, words[i % N]);
        end
`endif
        repeat (14) @(posedge clk);
        @(negedge clk);
        req = '0;
        repeat (3) @(posedge clk); #1;
        check_idle_outputs("t3_after");
        chk("t3_data",  data_out, words[0]);
        chk("t3_queue", gq.size() + cq.size(), 0);

        // Requester 2 abandons during its grant cycle
        @(negedge clk);
        set_word(2, 14'h2222);
        req = 4'b0100;
        push_g(2);
        @(posedge clk);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        check_idle_outputs("t4_abandon");
        chk("t4_data", data_out, words[0]);
        repeat (2) @(posedge clk); #1;
        chk("t4_ack_late", ack, 0);
        // Pointer unchanged by the abandon: search from 1 picks 1, not 3
        @(negedge clk);
        set_word(1, 14'h1111);
        set_word(3, 14'h3333);
        req = 4'b1010;
        push_g(1);
        push_c(1, 14'h1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req = '0;
        repeat (2) @(posedge clk); #1;
        chk("t4_owner", owner, 1);

        // Load 0x0055, then clear in the middle of a grant
        @(negedge clk);
        set_word(0, 14'h0055);
        req = 4'b0001;
        push_g(0);
        push_c(0, 14'h0055);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req = '0;
        repeat (2) @(posedge clk); #1;
        chk("t5_pre", data_out, 14'h0055);
        @(negedge clk);
        req = 4'b0001;
        push_g(0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("t5_clr_data", data_out, 0);
        check_idle_outputs("t5_clr");
        @(negedge clk);
        clr = 1'b0;
        set_word(0, 14'h0077);
        push_g(0);
        push_c(0, 14'h0077);
        repeat (2) @(posedge clk); #1;
        chk("t5_regrant", data_out, 14'h0077);
        @(negedge clk);
        req = '0;
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of a commit
        @(negedge clk);
        set_word(1, 14'h0123);
        req = 4'b0010;
        push_g(1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        chk("t6_rst_data",  data_out, 0);
        chk("t6_rst_owner", owner,    0);
        @(negedge clk);
        req = 4'b1000;
        set_word(3, 14'h2D5A);
        push_g(3);
        push_c(3, 14'h2D5A);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("t6_data",  data_out, 14'h2D5A);
        chk("t6_owner", owner,    3);
        @(negedge clk);
        req = '0;
        repeat (3) @(posedge clk); #1;
        check_idle_outputs("end");
        chk("end_gq", gq.size(), 0);
        chk("end_cq", cq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
